// File: rtl/commit_trace_buffer_pkg.sv
// Shared types for the commit trace buffer: drain FSM states, the stored
// record layout and the overflow counter ceiling.
package commit_trace_buffer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    B0   = 2'd1,
    B1   = 2'd2,
    B2   = 2'd3
  } drain_state_e;

  typedef struct packed {
    logic [7:0]  seq;
    logic [4:0]  idx;
    logic [31:0] data;
    logic [31:0] npc;
  } trace_rec_t;

  localparam int          REC_W       = $bits(trace_rec_t);
  localparam logic [15:0] OVF_CNT_MAX = 16'hFFFF;

  // First beat of a record: sequence number in the top byte, register index at the bottom.
  function automatic logic [31:0] header_beat(trace_rec_t rec);
    return {rec.seq, 19'b0, rec.idx};
  endfunction

endpackage

// File: rtl/commit_trace_buffer_fifo.sv
// Parameterised synchronous FIFO holding trace records. A push into a full
// FIFO is accepted only when a pop happens on the same edge.
module trace_fifo #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Pointers are AW bits wide, so the increment wraps modulo DEPTH by itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; entries are only read once count marks them valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/commit_trace_buffer.sv
// Captures register-writeback commits as sequenced records and drains each
// one as three beats (header, data, next-PC) over a valid/ready trace port.
module commit_trace_buffer
  import commit_trace_buffer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     commit_wr,
  input  logic [4:0]               commit_wr_idx,
  input  logic [31:0]              commit_wr_data,
  input  logic [31:0]              commit_NPC,
  output logic                     trace_valid,
  input  logic                     trace_ready,
  output logic [31:0]              trace_data,
  output logic                     trace_last,
  output logic                     ovf_flag,
  output logic [15:0]              ovf_cnt,
  input  logic                     ovf_clr,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int CW = $clog2(DEPTH) + 1;

  drain_state_e state, state_n;
  logic [7:0]   seq;
  trace_rec_t   wr_rec;
  trace_rec_t   head;
  logic         fifo_full;
  logic         fifo_empty;
  logic         qual;
  logic         pop;
  logic         accepted;
  logic         drop;

  assign qual     = commit_wr && (commit_wr_idx != 5'd0);
  assign pop      = (state == B2) && trace_ready;
  assign accepted = qual && (!fifo_full || pop);
  assign drop     = qual && fifo_full && !pop;

  assign wr_rec = '{seq: seq, idx: commit_wr_idx, data: commit_wr_data, npc: commit_NPC};

  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (qual),
    .pop   (pop),
    .wdata (wr_rec),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Leaving IDLE on the push itself gives the one-cycle commit-to-B0 latency.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_n     = state;
    trace_valid = 1'b0;
    trace_last  = 1'b0;
    trace_data  = '0;
    case (state)
      IDLE: if (!fifo_empty || accepted) state_n = B0;
      B0: begin
        trace_valid = 1'b1;
        trace_data  = header_beat(head);
        if (trace_ready) state_n = B1;
      end
      B1: begin
        trace_valid = 1'b1;
        trace_data  = head.data;
        if (trace_ready) state_n = B2;
      end
      B2: begin
        trace_valid = 1'b1;
        trace_last  = 1'b1;
        trace_data  = head.npc;
        if (trace_ready) state_n = (fifo_count > CW'(1) || accepted) ? B0 : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Sequence advances on every qualifying commit so dropped records leave gaps.
  always_ff @(posedge clk) begin
    if (rst) begin
      seq      <= '0;
      ovf_flag <= 1'b0;
      ovf_cnt  <= '0;
    end else begin
      if (qual) seq <= seq + 8'd1;
      if (ovf_clr) begin
        ovf_flag <= 1'b0;
        ovf_cnt  <= '0;
      end else if (drop) begin
        ovf_flag <= 1'b1;
        if (ovf_cnt != OVF_CNT_MAX) ovf_cnt <= ovf_cnt + 16'd1;
      end
    end
  end

endmodule

// File: doc/commit_trace_buffer.md
COMMIT_TRACE_BUFFER -- requirements
Module: commit_trace_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning the number of FIFO record entries (power of two, 2..64).
REQ-002 SHALL have port clk  in  1  system clock; all logic is on the rising edge.
REQ-003 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-004 SHALL have port commit_wr  in  1  the pipeline writeback-commit strobe.
REQ-005 SHALL have port commit_wr_idx  in  5  the destination register index.
REQ-006 SHALL have port commit_wr_data  in  32  the writeback data.
REQ-007 SHALL have port commit_NPC  in  32  the next-PC tag of the committed record.
REQ-008 SHALL have port trace_valid  out  1  a trace beat is presented.
REQ-009 SHALL have port trace_ready  in  1  the sink accepts the current beat.
REQ-010 SHALL have port trace_data  out  32  the beat payload.
REQ-011 SHALL have port trace_last  out  1  marks the final beat of a record.
REQ-012 SHALL have port ovf_flag  out  1  sticky flag set when a record is dropped.
REQ-013 SHALL have port ovf_cnt  out  16  the dropped-record count.
REQ-014 SHALL have port ovf_clr  in  1  clears ovf_flag and ovf_cnt.
REQ-015 SHALL have port fifo_count  out  $clog2(DEPTH)+1  the number of occupied entries.

Function
REQ-016 SHALL treat a cycle as a qualifying commit when commit_wr=1 and commit_wr_idx!=0.
REQ-017 SHALL form each record as {seq[7:0], idx[4:0], data[31:0], npc[31:0]}.
REQ-018 SHALL increment seq by 1 mod 256 on every qualifying commit, whether the record is stored or dropped, so that gaps expose drops.
REQ-019 SHALL push a qualifying commit into the FIFO when it is not full, or when it is full and a pop occurs in the same cycle.
REQ-020 SHALL drop a qualifying commit that arrives while the FIFO is full with no same-cycle pop; on a drop it sets ovf_flag and increments ovf_cnt, saturating at 16'hFFFF.
REQ-021 SHALL give ovf_clr priority over a same-cycle drop: ovf_flag=0 and ovf_cnt=0 next cycle.
REQ-022 SHALL implement the drain FSM with states IDLE, B0, B1, B2.
- IDLE -> B0 when fifo_count>0.
- B0 -> B1 on handshake.
- B1 -> B2 on handshake.
- B2 -> B0 on handshake when a further entry exists after the pop, otherwise -> IDLE.
- A handshake is trace_valid && trace_ready.
REQ-023 SHALL drive the beat payload as follows.
- B0: trace_data = {seq, 19'b0, idx}.
- B1: trace_data = data.
- B2: trace_data = npc, with trace_last=1.
- trace_last=0 in all other states.
REQ-024 SHALL assert trace_valid only in states B0, B1 and B2, and SHALL hold trace_data and trace_last stable while trace_valid=1 and trace_ready=0.
REQ-025 SHALL pop the head entry on the B2 handshake.
REQ-026 SHALL present a record pushed into an empty FIFO while in IDLE as B0 in the cycle after the push (1-cycle latency).
REQ-027 SHALL wrap the FIFO read and write pointers modulo DEPTH.
REQ-028 SHALL update fifo_count as +1 on push only, -1 on pop only, and unchanged on simultaneous push and pop.
REQ-029 SHALL sustain a throughput of one record per 3 cycles when trace_ready is held at 1.

Reset
REQ-030 SHALL, on rst=1 at a clock edge, set FSM=IDLE, both pointers=0, fifo_count=0, seq=0, ovf_flag=0, ovf_cnt=0, trace_valid=0, trace_last=0 and trace_data=0.
REQ-031 SHALL abandon any partially sent record on a mid-record reset: the next beat after reset is B0 of a newly pushed record.
REQ-032 SHALL give reset priority over commit, ovf_clr and handshake inputs.

Structure
REQ-033 SHALL place the drain state enum, the record typedef (seq/idx/data/npc) and the OVF_CNT_MAX constant in the shared package with the sys_defs macros.
REQ-034 SHALL implement the storage as one sub-module, trace_fifo: a parameterised synchronous FIFO with push/pop/full/empty/count; the FSM, sequencing and overflow logic remain in commit_trace_buffer.

Verification
REQ-035 SHALL cover single record: commit idx=5, data=32'hDEADBEEF, NPC=32'h104, trace_ready=1 -> beats 32'h00000005, 32'hDEADBEEF, 32'h00000104, with trace_last on the third beat only.
REQ-036 SHALL cover x0 filter: commit_wr=1 with idx=0 -> no beats produced, seq stays 0, fifo_count stays 0.
REQ-037 SHALL cover overflow: DEPTH=8, trace_ready=0, 10 qualifying commits -> fifo_count=8, ovf_cnt=2, ovf_flag=1; then trace_ready=1 -> B0 seq fields read 0..7, and the next commit carries seq=10.
REQ-038 SHALL cover backpressure: trace_ready toggling 1010... -> every beat is held stable while stalled, and no beat is duplicated or lost.
REQ-039 SHALL cover full with simultaneous pop: FIFO full, push coincident with B2 handshake -> record accepted, fifo_count stays 8, ovf_cnt unchanged.
REQ-040 SHALL cover reset mid-record: rst asserted in state B1 -> next cycle trace_valid=0 and fifo_count=0; the next commit emits seq=0.
